// File: rtl/sensor_value_solver.sv
// Inverts T(s) = base + (coef*s)>>3 by linear search for the smallest code s with T(s) >= target.
// Result is valid k+1 cycles after start is accepted (k = returned code); start is ignored while a solve is running.
module sensor_value_solver (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] factoryBaseTemp,
   input  logic [3:0] factoryTempCoef,
   input  logic [7:0] targetTemp,
   output logic       busy,
   output logic       done,
   output logic [3:0] sensorValue,
   output logic       exact,
   output logic       belowBase,
   output logic       saturated
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } solverState;

   solverState state;
   solverState nextState;

   logic [4:0] baseQ;
   logic [3:0] coefQ;
   logic [7:0] targetQ;
   logic [3:0] candidate;

   logic [7:0] product;
   logic [7:0] scaled;
   logic [7:0] tempAtCand;
   logic       hit;

   logic       loadOps;
   logic       advance;
   logic       capture;

   // Forward model on the latched operands; 15*15 fits in 8 bits, so no overflow.
   always_comb begin
      product    = {4'b0000, coefQ} * {4'b0000, candidate};
      scaled     = product >> 3;
      tempAtCand = {3'b000, baseQ} + scaled;
      hit        = (tempAtCand >= targetQ);
   end

   always_comb begin
      nextState = state;
      busy      = 1'b0;
      done      = 1'b0;
      loadOps   = 1'b0;
      advance   = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               loadOps   = 1'b1;
               nextState = SEARCH;
            end
         end
         SEARCH: begin
            busy = 1'b1;
            if (hit || (candidate == 4'd15)) begin
               capture   = 1'b1;
               nextState = DONE;
            end else begin
               advance = 1'b1;
            end
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         baseQ       <= 5'd0;
         coefQ       <= 4'd0;
         targetQ     <= 8'd0;
         candidate   <= 4'd0;
         sensorValue <= 4'd0;
         exact       <= 1'b0;
         belowBase   <= 1'b0;
         saturated   <= 1'b0;
      end else begin
         state <= nextState;
         if (loadOps) begin
            baseQ     <= factoryBaseTemp;
            coefQ     <= factoryTempCoef;
            targetQ   <= targetTemp;
            candidate <= 4'd0;
         end else if (advance) begin
            candidate <= candidate + 4'd1;
         end
         // A miss at code 15 means T never reaches the target, so exact is necessarily 0 there.
         if (capture) begin
            sensorValue <= candidate;
            exact       <= (tempAtCand == targetQ);
            belowBase   <= (targetQ < {3'b000, baseQ});
            saturated   <= ~hit;
         end
      end
   end

endmodule
